// File: rtl/onc_uart_tx_if.sv
// CPU data-memory bus as seen by the UART transmitter.
//   addr : data-memory address from the CPU
//   din  : write data from the CPU
//   we   : write enable, sampled on the rising clock edge
//   dout : read data returned to the CPU, combinational from addr
// The master modport is the CPU side; the slave modport is the peripheral side.
interface onc_uart_tx_if;
  logic [15:0] addr;
  logic [15:0] din;
  logic        we;
  logic [15:0] dout;

  modport master (output addr, output din, output we, input dout);
  modport slave  (input addr, input din, input we, output dout);
endinterface

// File: rtl/onc_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX buffer.
//   clock : system clock, all state updates on the rising edge
//   n_rst : asynchronous active-low reset
//   bus   : CPU data-memory bus (slave modport)
//           BASE_ADDR   write pushes din[7:0] into the TX buffer, reads 0
//           BASE_ADDR+1 read {12'h0, ovf, empty, full, busy}; write din[3]=1 clears ovf
//   txd   : serial output, idle high, LSB first, registered
// Optional feature macro: ONC_UART_TX_FIFO_EN selects a 4-entry FIFO buffer;
// without it the buffer is a single holding register.
module onc_uart_tx #(
  parameter int unsigned CLK_DIV   = 16,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic             clock,
  input  logic             n_rst,
  onc_uart_tx_if.slave     bus,
  output logic             txd
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [15:0] StatAddr = BASE_ADDR + 16'd1;
  localparam logic [15:0] DivLast  = 16'(CLK_DIV - 1);

  state_e      state_q;
  logic [15:0] div_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        ovf_q;

  logic       push, pop, accept, full, empty, div_end;
  logic [7:0] head;

  assign push    = bus.we && (bus.addr == BASE_ADDR);
  assign div_end = (div_q == DivLast);
  // Head leaves the buffer when idle, or on the last stop cycle for a gapless next frame.
  assign pop     = !empty && ((state_q == StIdle) || ((state_q == StStop) && div_end));
  // A push into a full buffer still lands if a slot frees in the same cycle.
  assign accept  = push && (!full || pop);

  // Only the byte lane and the ovf-clear bit of din carry meaning.
  logic unused_din;
  assign unused_din = ^bus.din[15:8];

`ifdef ONC_UART_TX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;

  assign full  = (count_q == 3'd4);
  assign empty = (count_q == 3'd0);
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 2'd1;
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (accept) mem_q[wr_ptr_q] <= bus.din[7:0];
  end
`else
  logic [7:0] hold_q;
  logic       occ_q;

  assign full  = occ_q;
  assign empty = !occ_q;
  assign head  = hold_q;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      occ_q  <= 1'b0;
      hold_q <= 8'h00;
    end else begin
      if (accept) begin
        occ_q  <= 1'b1;
        hold_q <= bus.din[7:0];
      end else if (pop) begin
        occ_q  <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
    end else if (push && full && !pop) begin
      ovf_q <= 1'b1;
    end else if (bus.we && (bus.addr == StatAddr) && bus.din[3]) begin
      ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      div_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      txd     <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          txd   <= 1'b1;
          div_q <= 16'd0;
          if (!empty) begin
            state_q <= StStart;
            shift_q <= head;
            txd     <= 1'b0;
          end
        end
        StStart: begin
          if (div_end) begin
            div_q   <= 16'd0;
            bit_q   <= 3'd0;
            state_q <= StData;
            txd     <= shift_q[0];
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        StData: begin
          if (div_end) begin
            div_q <= 16'd0;
            if (bit_q == 3'd7) begin
              state_q <= StStop;
              txd     <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              txd     <= shift_q[1];
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        StStop: begin
          if (div_end) begin
            div_q <= 16'd0;
            if (!empty) begin
              state_q <= StStart;
              shift_q <= head;
              txd     <= 1'b0;
            end else begin
              state_q <= StIdle;
              txd     <= 1'b1;
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          txd     <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    bus.dout = 16'h0000;
    if (bus.addr == StatAddr) begin
      bus.dout = {12'h000, ovf_q, empty, full, (state_q != StIdle)};
    end
  end

endmodule

// File: tb/tb_onc_uart_tx.sv
// Directed bench for onc_uart_tx: reset, single frame, back-to-back frames,
// overflow, push+pop at frame boundary, and mid-frame reset.
module tb_onc_uart_tx;
  localparam int          CLK_DIV = 16;
  localparam int          FRAME   = 10 * CLK_DIV;
  localparam logic [15:0] BASE    = 16'hFF00;
  localparam logic [15:0] STAT    = 16'hFF01;
`ifdef ONC_UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clock = 1'b0;
  logic n_rst = 1'b0;
  logic txd;
  int   cyc = 0;

  onc_uart_tx_if bus ();

  onc_uart_tx #(.CLK_DIV(CLK_DIV), .BASE_ADDR(BASE)) dut (
    .clock (clock),
    .n_rst (n_rst),
    .bus   (bus),
    .txd   (txd)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Receiver: every bit period must hold one value for all CLK_DIV cycles.
  logic [7:0] rx_q[$];
  int         rx_start[$];
  int         rx_bad = 0;

  initial begin
    logic [9:0] val;
    logic       ok, aborted, v;
    int         st;
    forever begin
      @(negedge clock);
      if (n_rst && txd == 1'b0) begin
        st = cyc; ok = 1'b1; aborted = 1'b0; val = '0;
        for (int b = 0; b < 10; b++) begin
          for (int j = 0; j < CLK_DIV; j++) begin
            if (!(b == 0 && j == 0)) @(negedge clock);
            if (!n_rst) aborted = 1'b1;
            v = txd;
            if (j == 0) val[b] = v;
            else if (v != val[b]) ok = 1'b0;
          end
        end
        if (!aborted) begin
          if (val[0] != 1'b0 || val[9] != 1'b1) ok = 1'b0;
          rx_q.push_back(val[8:1]);
          rx_start.push_back(st);
          if (!ok) rx_bad++;
        end
      end
    end
  end

  // Called at a negedge; returns at the next negedge after the write edge.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    bus.addr = a; bus.din = d; bus.we = 1'b1;
    @(negedge clock);
  endtask

  task automatic bus_idle();
    bus.we = 1'b0; bus.din = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    bus.we = 1'b0; bus.addr = a;
    #1 d = bus.dout;
  endtask

  task automatic wait_rx(input int n, input int limit);
    int t = 0;
    while (rx_q.size() < n && t < limit) begin
      @(negedge clock);
      t++;
    end
    check("rx_count", rx_q.size(), n);
  endtask

  task automatic clear_rx();
    rx_q.delete(); rx_start.delete(); rx_bad = 0;
  endtask

  initial begin
    logic [15:0] d;
    logic        stuck;
    int          wr_cyc;

    bus.addr = 16'h0000; bus.din = 16'h0000; bus.we = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_txd", txd, 1'b1);
    bus_read(STAT, d); check("rst_status", d, 16'h0004);
    @(negedge clock);
    n_rst = 1'b1;
    stuck = 1'b1;
    repeat (20) begin @(negedge clock); if (txd !== 1'b1) stuck = 1'b0; end
    check("idle_txd_high", stuck, 1'b1);
    bus_read(STAT, d); check("idle_status", d, 16'h0004);
    bus_read(BASE, d); check("data_reads_zero", d, 16'h0000);
    bus_read(16'h1234, d); check("other_addr_zero", d, 16'h0000);
    @(negedge clock);

    // Single byte, upper data byte must be ignored.
    clear_rx();
    bus_write(BASE, 16'h5548);
    wr_cyc = cyc;
    bus_idle();
    repeat (40) @(negedge clock);
    bus_read(STAT, d); check("busy_status", d, 16'h0005);
    wait_rx(1, FRAME + 50);
    check("single_byte", rx_q[0], 8'h48);
    check("single_latency", rx_start[0], wr_cyc + 1);
    check("single_bits_width", rx_bad, 0);
    @(negedge clock);
    bus_read(STAT, d); check("single_done_status", d, 16'h0004);
    repeat (5) @(negedge clock);

    // Back-to-back 'h','i'.
    clear_rx();
    bus_write(BASE, 16'h0068);
    bus_write(BASE, 16'h0069);
    bus_idle();
    wait_rx(2, 2 * FRAME + 50);
    check("b2b_first", rx_q[0], 8'h68);
    check("b2b_second", rx_q[1], 8'h69);
    check("b2b_contiguous", rx_start[1] - rx_start[0], FRAME);
    check("b2b_bits_width", rx_bad, 0);
    repeat (3) @(negedge clock);

    // Overflow: DEPTH bytes buffered behind the first, the rest dropped.
    clear_rx();
    for (int i = 0; i < 6; i++) bus_write(BASE, 16'(16'h0041 + i));
    bus_idle();
    bus_read(STAT, d); check("ovf_set_status", d, 16'h000B);
    @(negedge clock);
    bus_write(STAT, 16'h0007);
    bus_idle();
    bus_read(STAT, d); check("ovf_kept_bit3_0", d, 16'h000B);
    @(negedge clock);
    bus_write(STAT, 16'h0008);
    bus_idle();
    bus_read(STAT, d); check("ovf_cleared", d, 16'h0003);
    wait_rx(DEPTH + 1, (DEPTH + 2) * FRAME);
    for (int i = 0; i < DEPTH + 1 && i < rx_q.size(); i++)
      check("ovf_byte", rx_q[i], 32'(8'h41 + i));
    repeat (FRAME + 20) @(negedge clock);
    check("ovf_dropped", rx_q.size(), DEPTH + 1);
    check("ovf_bits_width", rx_bad, 0);
    bus_read(STAT, d); check("ovf_done_status", d, 16'h0004);
    @(negedge clock);

    // Full buffer, push lands on the same edge as the STOP-end pop.
    clear_rx();
    bus_write(BASE, 16'h0010);
    wr_cyc = cyc;
    for (int i = 0; i < DEPTH; i++) bus_write(BASE, 16'(16'h0020 + i));
    bus_idle();
    bus_read(STAT, d); check("pp_full_status", d, 16'h0003);
    while (cyc < wr_cyc + FRAME) @(negedge clock);
    bus_write(BASE, 16'h007E);
    bus_idle();
    bus_read(STAT, d); check("pp_no_ovf", d, 16'h0003);
    wait_rx(DEPTH + 2, (DEPTH + 3) * FRAME);
    if (rx_q.size() == DEPTH + 2) begin
      check("pp_byte_first", rx_q[0], 8'h10);
      for (int i = 0; i < DEPTH; i++) check("pp_byte_mid", rx_q[i + 1], 32'(8'h20 + i));
      check("pp_byte_last", rx_q[DEPTH + 1], 8'h7E);
      for (int i = 1; i < DEPTH + 2; i++)
        check("pp_contiguous", rx_start[i] - rx_start[i - 1], FRAME);
    end
    check("pp_bits_width", rx_bad, 0);
    repeat (5) @(negedge clock);

    // Mid-frame reset during bit 3 (a zero bit of 0xA5).
    clear_rx();
    bus_write(BASE, 16'h00A5);
    wr_cyc = cyc;
    bus_write(BASE, 16'h0033);
    bus_idle();
    while (cyc < wr_cyc + 1 + 4 * CLK_DIV + CLK_DIV / 2) @(negedge clock);
    check("midrst_txd_before", txd, 1'b0);
    #2 n_rst = 1'b0;
    #1 check("midrst_txd_async", txd, 1'b1);
    bus_read(STAT, d); check("midrst_status", d, 16'h0004);
    @(negedge clock);
    n_rst = 1'b1;
    stuck = 1'b1;
    repeat (2 * FRAME) begin @(negedge clock); if (txd !== 1'b1) stuck = 1'b0; end
    check("midrst_no_resume", stuck, 1'b1);
    check("midrst_no_frames", rx_q.size(), 0);
    bus_read(STAT, d); check("midrst_after_status", d, 16'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onc_uart_tx.md
ONC_UART_TX -- requirements
Module: onc_uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 16, clocks per serial bit (legal range 2..65535).
REQ-002 Parameter BASE_ADDR, default 16'hFF00, data-memory address of the DATA register; STATUS is at BASE_ADDR+1.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 addr  input  16  data-memory address from CPU (dmem_addr).
REQ-006 din  input  16  write data from CPU (dmem_dout).
REQ-007 we  input  1  write enable from CPU (dmem_we), sampled on rising clock.
REQ-008 dout  output  16  read data to CPU (dmem_din mux), combinational from addr and state.
REQ-009 txd  output  1  serial output, idle high, 8N1, LSB first.

Function
REQ-010 Write with we=1 and addr=BASE_ADDR SHALL push din[7:0] into the TX buffer; din[15:8] ignored.
REQ-011 Write with we=1 and addr=BASE_ADDR+1 and din[3]=1 SHALL clear the sticky overflow flag; other bits ignored.
REQ-012 dout at addr=BASE_ADDR+1 SHALL be {12'h000, ovf, empty, full, busy}; busy=state!=IDLE, full/empty reflect buffer occupancy.
REQ-013 dout at addr=BASE_ADDR SHALL be 16'h0000; dout at any other address SHALL be 16'h0000.
REQ-014 Push when buffer full (and no pop in the same cycle) SHALL drop the byte and set ovf=1; buffer contents unchanged.
REQ-015 Push and pop in the same cycle SHALL both take effect; occupancy unchanged; a push to a full buffer with simultaneous pop is accepted, ovf not set.
REQ-016 State machine IDLE, START, DATA, STOP; bit counter 0..7; divide counter 0..CLK_DIV-1.
REQ-017 IDLE: txd=1; when buffer non-empty, pop head into shift register and go to START at next edge.
REQ-018 START: txd=0 for exactly CLK_DIV cycles, then DATA with bit index 0.
REQ-019 DATA: txd=shift[0] for CLK_DIV cycles per bit, shift right after each bit; after bit 7 go to STOP.
REQ-020 STOP: txd=1 for CLK_DIV cycles; at its final cycle, if buffer non-empty, pop and go directly to START (no idle gap), else go to IDLE.
REQ-021 Latency: byte written at edge N into empty buffer with state IDLE SHALL drive txd=0 from edge N+2 (edge N+1 pops, N+2 enters START... ) -- fixed: pop occurs at edge N+1, txd=0 after edge N+1.
REQ-022 Frame length SHALL be exactly 10*CLK_DIV clock cycles; back-to-back frames SHALL be contiguous.
REQ-023 Byte order on txd SHALL equal write order (FIFO).
REQ-024 txd SHALL be driven from a register (glitch-free).

Reset
REQ-025 n_rst=0 SHALL immediately force txd=1, state=IDLE, counters=0, buffer empty, ovf=0, without waiting for clock.
REQ-026 Reset asserted mid-frame SHALL abort the frame; buffered bytes are discarded; after release no partial frame resumes.
REQ-027 After reset, dout at STATUS SHALL read 16'h0004.

Configuration
REQ-028 Macro ONC_UART_TX_FIFO_EN defined: TX buffer is a 4-entry circular FIFO, 2-bit read/write pointers wrapping 3->0, 3-bit occupancy count.
REQ-029 ONC_UART_TX_FIFO_EN undefined: TX buffer is a single holding register (depth 1); full=occupied, empty=!occupied; all push/pop/overflow rules above apply with depth 1.

Verification
REQ-030 Reset: n_rst=0 then release, no writes -> txd=1 steady, STATUS=16'h0004.
REQ-031 Single byte: CLK_DIV=16, write 16'h0048 to FF00 -> txd after pop edge: 0 (16 cyc), bits 0,0,0,1,0,0,1,0 (16 cyc each), 1 (16 cyc); 160-cycle frame; STATUS busy=1 during, 16'h0004 after.
REQ-032 Back-to-back: FIFO_EN, write 'h','i' on consecutive cycles -> two contiguous 160-cycle frames, no idle between, order 'h' then 'i'.
REQ-033 Overflow: FIFO_EN, 6 consecutive writes 0x41..0x46 while IDLE -> first pops immediately, 0x42..0x45 buffered, 0x46 dropped, STATUS bit3=1 and full=1; write 16'h0008 to FF01 -> bit3=0; txd shows 0x41..0x45 only.
REQ-034 Push+pop same cycle with full buffer at STOP end -> byte accepted, ovf stays 0, all bytes transmitted.
REQ-035 Mid-frame reset: assert n_rst at bit 3 of a frame -> txd=1 immediately, STATUS=16'h0004, no further frame after release.
